// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction fetch front end. Fetches the word at the current PC from the
//   icache (hit) or from the memory controller (miss), predicts the next PC
//   from the word (JAL / predicted branch), and queues {inst, PC, pred} in an
//   IFQ_DEPTH-entry FIFO so fetch can run ahead while decode is stalled.
//   Memory-fetched words are written back to the icache with a one-cycle
//   fill strobe. A ROB redirect (clr_in) empties the queue and restarts fetch
//   at the redirect target, discarding any memory response already in flight.
//
// Ports
//   clk_in, rst_in             clock, synchronous active-high reset
//   rdy_in                     global enable; low freezes every register
//   clr_in, rob_to_if_alter_PC redirect strobe and target
//   ic_to_if_hit/_hit_inst     icache lookup result for if_to_ic_addr
//   if_to_ic_addr              lookup address (current fetch PC)
//   if_to_ic_fill_*            one-cycle icache fill strobe + payload
//   if_to_mc_ready/_PC         memory request, held until mc_to_if_ready
//   mc_to_if_ready/_inst       one-cycle memory response strobe + word
//   if_to_pr_PC                predictor lookup address (current fetch PC)
//   pr_to_if_prediction        predicted taken for if_to_pr_PC
//   stall                      decoder cannot accept this cycle
//   if_to_dc_ready/_inst/_PC/_pred_br  one-cycle dequeued entry to decode

module inst_fetch_queue #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter int                    IFQ_DEPTH  = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clr_in,
   input  logic [ADDR_WIDTH-1:0] rob_to_if_alter_PC,
   input  logic                  ic_to_if_hit,
   input  logic [INST_WIDTH-1:0] ic_to_if_hit_inst,
   output logic [ADDR_WIDTH-1:0] if_to_ic_addr,
   output logic                  if_to_ic_fill_valid,
   output logic [ADDR_WIDTH-1:0] if_to_ic_fill_addr,
   output logic [INST_WIDTH-1:0] if_to_ic_fill_inst,
   output logic                  if_to_mc_ready,
   output logic [ADDR_WIDTH-1:0] if_to_mc_PC,
   input  logic                  mc_to_if_ready,
   input  logic [INST_WIDTH-1:0] mc_to_if_inst,
   output logic [ADDR_WIDTH-1:0] if_to_pr_PC,
   input  logic                  pr_to_if_prediction,
   input  logic                  stall,
   output logic                  if_to_dc_ready,
   output logic [INST_WIDTH-1:0] if_to_dc_inst,
   output logic [ADDR_WIDTH-1:0] if_to_dc_PC,
   output logic                  if_to_dc_pred_br
);

   localparam int PTR_W = (IFQ_DEPTH > 1) ? $clog2(IFQ_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IFQ_DEPTH);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM_WAIT,
      S_DRAIN
   } state_e;

   typedef struct packed {
      logic [INST_WIDTH-1:0] inst;
      logic [ADDR_WIDTH-1:0] pc;
      logic                  pred;
   } ifq_entry_t;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   ifq_entry_t            mem_q [IFQ_DEPTH];
   logic                  req_q, req_d;
   logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
   logic                  fill_v_q, fill_v_d;
   logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
   logic [INST_WIDTH-1:0] fill_inst_q, fill_inst_d;
   logic                  dc_v_q, dc_v_d;
   ifq_entry_t            dc_q, dc_d;

   logic [INST_WIDTH-1:0] fetch_w;
   logic [31:0]           j_imm, b_imm;
   logic [ADDR_WIDTH-1:0] seq_pc, npc;
   logic                  fetch_pred;
   ifq_entry_t            push_e;
   logic                  push, pop, can_push;

   // Predecode of the word being fetched this cycle. In MEM_WAIT the PC has
   // not moved since the request, so the predictor answer still refers to it.
   always_comb begin
      fetch_w    = (state_q == S_MEM_WAIT) ? mc_to_if_inst : ic_to_if_hit_inst;
      j_imm      = {{12{fetch_w[31]}}, fetch_w[19:12], fetch_w[20], fetch_w[30:21], 1'b0};
      b_imm      = {{20{fetch_w[31]}}, fetch_w[7], fetch_w[30:25], fetch_w[11:8], 1'b0};
      seq_pc     = pc_q + ADDR_WIDTH'(4);
      npc        = seq_pc;
      fetch_pred = pr_to_if_prediction;
      case (fetch_w[6:0])
         OP_JALR: begin
            npc        = seq_pc;
            fetch_pred = 1'b0;
         end
         OP_JAL: begin
            npc        = pc_q + ADDR_WIDTH'(signed'(j_imm));
            fetch_pred = 1'b1;
         end
         OP_BRANCH: begin
            if (pr_to_if_prediction) begin
               npc        = pc_q + ADDR_WIDTH'(signed'(b_imm));
               fetch_pred = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign push_e = '{inst: fetch_w, pc: pc_q, pred: fetch_pred};

   // Next-state logic. With rdy_in low every _d equals its _q.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      req_pc_d    = req_pc_q;
      fill_v_d    = fill_v_q;
      fill_addr_d = fill_addr_q;
      fill_inst_d = fill_inst_q;
      dc_v_d      = dc_v_q;
      dc_d        = dc_q;
      push        = 1'b0;
      pop         = 1'b0;
      can_push    = 1'b0;

      if (rdy_in) begin
         fill_v_d = 1'b0;
         if (clr_in) begin
            // Redirect wins over any push/pop this cycle.
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            dc_v_d = 1'b0;
            pc_d   = rob_to_if_alter_PC;
            case (state_q)
               S_MEM_WAIT: begin
                  // A same-cycle response is simply dropped; otherwise the
                  // response is still owed to us and must be swallowed.
                  req_d   = 1'b0;
                  state_d = mc_to_if_ready ? S_IDLE : S_DRAIN;
               end
               S_DRAIN: begin
                  if (mc_to_if_ready) state_d = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
         end else begin
            pop      = !stall && (cnt_q != '0);
            // Popping frees the head slot in the same cycle.
            can_push = (cnt_q < DEPTH_C) || pop;
            dc_v_d   = pop;
            if (pop) dc_d = mem_q[head_q];

            case (state_q)
               S_IDLE: begin
                  if (can_push) begin
                     if (ic_to_if_hit) begin
                        push = 1'b1;
                        pc_d = npc;
                     end else begin
                        // The free slot seen here stays free until the
                        // response: nothing else pushes while we wait.
                        req_d    = 1'b1;
                        req_pc_d = pc_q;
                        state_d  = S_MEM_WAIT;
                     end
                  end
               end
               S_MEM_WAIT: begin
                  if (mc_to_if_ready) begin
                     push        = 1'b1;
                     fill_v_d    = 1'b1;
                     fill_addr_d = pc_q;
                     fill_inst_d = mc_to_if_inst;
                     req_d       = 1'b0;
                     pc_d        = npc;
                     state_d     = S_IDLE;
                  end
               end
               S_DRAIN: begin
                  if (mc_to_if_ready) state_d = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase

            if (pop)  head_d = head_q + PTR_W'(1);
            if (push) tail_d = tail_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         req_q       <= 1'b0;
         req_pc_q    <= '0;
         fill_v_q    <= 1'b0;
         fill_addr_q <= '0;
         fill_inst_q <= '0;
         dc_v_q      <= 1'b0;
         dc_q        <= '0;
         for (int i = 0; i < IFQ_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         req_pc_q    <= req_pc_d;
         fill_v_q    <= fill_v_d;
         fill_addr_q <= fill_addr_d;
         fill_inst_q <= fill_inst_d;
         dc_v_q      <= dc_v_d;
         dc_q        <= dc_d;
         if (push) mem_q[tail_q] <= push_e;
      end
   end

   assign if_to_ic_addr       = pc_q;
   assign if_to_pr_PC         = pc_q;
   assign if_to_ic_fill_valid = fill_v_q;
   assign if_to_ic_fill_addr  = fill_addr_q;
   assign if_to_ic_fill_inst  = fill_inst_q;
   assign if_to_mc_ready      = req_q;
   assign if_to_mc_PC         = req_pc_q;
   assign if_to_dc_ready      = dc_v_q;
   assign if_to_dc_inst       = dc_q.inst;
   assign if_to_dc_PC         = dc_q.pc;
   assign if_to_dc_pred_br    = dc_q.pred;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clr_in, stall;
   logic [31:0] rob_to_if_alter_PC;
   logic        ic_to_if_hit;
   logic [31:0] ic_to_if_hit_inst;
   logic [31:0] if_to_ic_addr;
   logic        if_to_ic_fill_valid;
   logic [31:0] if_to_ic_fill_addr, if_to_ic_fill_inst;
   logic        if_to_mc_ready;
   logic [31:0] if_to_mc_PC;
   logic        mc_to_if_ready;
   logic [31:0] mc_to_if_inst;
   logic [31:0] if_to_pr_PC;
   logic        pr_to_if_prediction;
   logic        if_to_dc_ready;
   logic [31:0] if_to_dc_inst, if_to_dc_PC;
   logic        if_to_dc_pred_br;

   inst_fetch_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .IFQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
      .rob_to_if_alter_PC(rob_to_if_alter_PC),
      .ic_to_if_hit(ic_to_if_hit), .ic_to_if_hit_inst(ic_to_if_hit_inst),
      .if_to_ic_addr(if_to_ic_addr), .if_to_ic_fill_valid(if_to_ic_fill_valid),
      .if_to_ic_fill_addr(if_to_ic_fill_addr), .if_to_ic_fill_inst(if_to_ic_fill_inst),
      .if_to_mc_ready(if_to_mc_ready), .if_to_mc_PC(if_to_mc_PC),
      .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst),
      .if_to_pr_PC(if_to_pr_PC), .pr_to_if_prediction(pr_to_if_prediction),
      .stall(stall), .if_to_dc_ready(if_to_dc_ready), .if_to_dc_inst(if_to_dc_inst),
      .if_to_dc_PC(if_to_dc_PC), .if_to_dc_pred_br(if_to_dc_pred_br)
   );

   always #5 clk_in = ~clk_in;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- program image ----------------
   // kind: 0 ADDI, 1 JAL, 2 BRANCH, 3 JALR. imm is the intended byte offset.
   int dir_k [logic [31:0]];
   int dir_i [logic [31:0]];
   bit prog_hashed = 1'b0;

   function automatic logic [31:0] enc(input int kind, input int imm);
      logic [31:0] v;
      v = imm;
      case (kind)
         1:       enc = {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
         2:       enc = {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], 7'b1100011};
         3:       enc = 32'h000080E7;
         default: enc = 32'h00100093;
      endcase
   endfunction

   function automatic void gen(input logic [31:0] pc, output int kind, output int imm,
                               output logic [31:0] w);
      logic [31:0] h;
      int sel;
      kind = 0;
      imm  = 0;
      if (dir_k.exists(pc)) begin
         kind = dir_k[pc];
         imm  = dir_i[pc];
      end else if (prog_hashed) begin
         h = pc * 32'h9E3779B1;
         h = h ^ (h >> 15);
         sel = int'(h % 10);
         if (sel < 2)       begin kind = 1; imm = (int'(h >> 20) % 2048 - 1024) * 4; end
         else if (sel < 4)  begin kind = 2; imm = (int'(h >> 21) % 1024 - 512) * 4; end
         else if (sel == 4) kind = 3;
      end
      w = enc(kind, imm);
   endfunction

   // Next PC / prediction from the instruction's intended meaning.
   function automatic void predict(input logic [31:0] pc, input bit p, output logic [31:0] npc,
                                   output bit pred, output logic [31:0] w);
      int k, im;
      gen(pc, k, im, w);
      npc  = pc + 32'd4;
      pred = p;
      case (k)
         1: begin npc = pc + 32'(im); pred = 1'b1; end
         2: if (p) begin npc = pc + 32'(im); pred = 1'b1; end
         3: pred = 1'b0;
         default: ;
      endcase
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed { logic [31:0] inst; logic [31:0] pc; logic pred; } ent_t;
   ent_t        q[$];
   int          m_st;            // 0 idle, 1 waiting on memory, 2 draining
   logic [31:0] m_pc, m_req_pc, m_fill_a, m_fill_i;
   bit          m_req, m_fill_v, m_dc_v;
   ent_t        m_dc;

   // memory controller behaviour
   bit          mc_pend, mc_stale, mc_lat_rand;
   int          mc_cnt, mc_lat = 3;
   logic [31:0] mc_addr;

   task automatic model_reset();
      q.delete();
      m_st = 0; m_pc = 32'h0; m_req = 0; m_req_pc = 0;
      m_fill_v = 0; m_fill_a = 0; m_fill_i = 0; m_dc_v = 0; m_dc = '0;
   endtask

   task automatic step(input bit rdy, input bit stl, input bit clr, input logic [31:0] alt,
                       input bit hit, input bit prd, input bit bogus);
      logic [31:0] w, npc, mw;
      bit pd, pop, room;
      int k, im;
      rdy_in = rdy; stall = stl; clr_in = clr; rob_to_if_alter_PC = alt;
      ic_to_if_hit = hit; pr_to_if_prediction = prd;
      mc_to_if_ready = 1'b0;
      mc_to_if_inst  = $urandom();

      if (!mc_pend && m_req) begin
         mc_pend = 1'b1;
         mc_addr = m_req_pc;
         mc_cnt  = mc_lat_rand ? $urandom_range(0, 5) : mc_lat;
      end
      if (rdy) begin
         if (mc_stale) begin
            mc_to_if_ready = 1'b1;
            mc_stale = 1'b0;
         end else if (mc_pend) begin
            if (mc_cnt == 0) begin
               gen(mc_addr, k, im, mw);
               mc_to_if_ready = 1'b1;
               mc_to_if_inst  = mw;
               mc_pend = 1'b0;
            end else mc_cnt--;
         end
      end else if (bogus) mc_to_if_ready = 1'b1;

      predict(m_pc, prd, npc, pd, w);
      ic_to_if_hit_inst = w;
      if (m_st == 1) w = mc_to_if_inst;

      if (rdy) begin
         m_fill_v = 1'b0;
         if (clr) begin
            q.delete();
            m_dc_v = 1'b0;
            m_pc = alt;
            if (m_st == 1) begin
               m_req = 1'b0;
               m_st = mc_to_if_ready ? 0 : 2;
            end else if (m_st == 2) begin
               if (mc_to_if_ready) m_st = 0;
            end else m_st = 0;
         end else begin
            pop  = !stl && q.size() > 0;
            room = q.size() < DEPTH || pop;
            m_dc_v = pop;
            if (pop) m_dc = q.pop_front();
            if (m_st == 0) begin
               if (room) begin
                  if (hit) begin
                     q.push_back('{inst: w, pc: m_pc, pred: pd});
                     m_pc = npc;
                  end else begin
                     m_req = 1'b1; m_req_pc = m_pc; m_st = 1;
                  end
               end
            end else if (m_st == 1) begin
               if (mc_to_if_ready) begin
                  q.push_back('{inst: w, pc: m_pc, pred: pd});
                  m_fill_v = 1'b1; m_fill_a = m_pc; m_fill_i = w;
                  m_req = 1'b0; m_pc = npc; m_st = 0;
               end
            end else if (mc_to_if_ready) m_st = 0;
         end
      end

      @(posedge clk_in);
      #1;
      chk("dc_ready", if_to_dc_ready, m_dc_v);
      if (m_dc_v) begin
         chk("dc_pc", if_to_dc_PC, m_dc.pc);
         chk("dc_inst", if_to_dc_inst, m_dc.inst);
         chk("dc_pred", if_to_dc_pred_br, m_dc.pred);
      end
      chk("fill_valid", if_to_ic_fill_valid, m_fill_v);
      if (m_fill_v) begin
         chk("fill_addr", if_to_ic_fill_addr, m_fill_a);
         chk("fill_inst", if_to_ic_fill_inst, m_fill_i);
      end
      chk("mc_req", if_to_mc_ready, m_req);
      if (m_req) chk("mc_pc", if_to_mc_PC, m_req_pc);
      chk("ic_addr", if_to_ic_addr, m_pc);
      chk("pr_pc", if_to_pr_PC, m_pc);
   endtask

   task automatic do_reset();
      rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; stall = 1'b0;
      ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'h00100093;
      mc_to_if_ready = 1'b0; pr_to_if_prediction = 1'b0; rob_to_if_alter_PC = 32'h0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      model_reset();
      // A response owed from before reset still arrives; it must be ignored.
      mc_stale = mc_pend;
      mc_pend  = 1'b0;
      chk("rst_dc_ready", if_to_dc_ready, 0);
      chk("rst_dc_inst", if_to_dc_inst, 0);
      chk("rst_dc_pc", if_to_dc_PC, 0);
      chk("rst_dc_pred", if_to_dc_pred_br, 0);
      chk("rst_fill", {if_to_ic_fill_valid, if_to_ic_fill_addr, if_to_ic_fill_inst}, 0);
      chk("rst_mc", {if_to_mc_ready, if_to_mc_PC}, 0);
      chk("rst_pc", if_to_ic_addr, 32'h0);
   endtask

   logic [31:0] got[$];
   bit seen_fill, seen_dc, done;
   logic [31:0] alt;

   initial begin
      mc_pend = 0; mc_stale = 0; mc_lat_rand = 0;
      do_reset();

      // Straight-line hits, no stall: one instruction per cycle to decode.
      got.delete();
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 0, 0, 1, 0, 0);
         if (if_to_dc_ready) got.push_back(if_to_dc_PC);
      end
      chk("t1_cnt", got.size(), 11);
      for (int i = 0; i < 8 && i < got.size(); i++) chk("t1_pc", got[i], 64'(i * 4));

      // Decode stalled: queue fills to DEPTH and fetch stops.
      do_reset();
      for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1, 0, 0);
      chk("t2_pc", if_to_ic_addr, 32'h10);
      chk("t2_nodc", if_to_dc_ready, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 1, 0, 0);
         chk("t2_rdy", if_to_dc_ready, 1);
         chk("t2_pc_out", if_to_dc_PC, 64'(i * 4));
      end

      // Miss at 0x40, response after 5 cycles.
      do_reset();
      mc_lat = 5;
      step(1, 0, 1, 32'h40, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("t3_req", if_to_mc_ready, 1);
      chk("t3_req_pc", if_to_mc_PC, 32'h40);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         if (if_to_ic_fill_valid) begin
            done = 1;
            chk("t3_fill_addr", if_to_ic_fill_addr, 32'h40);
            chk("t3_fill_inst", if_to_ic_fill_inst, 32'h00100093);
         end
      end
      chk("t3_fill_seen", done, 1);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("t3_dc", {if_to_dc_ready, if_to_dc_PC}, {1'b1, 32'h40});

      // JAL and predicted-taken branch targets.
      do_reset();
      mc_lat = 3;
      dir_k[32'h100] = 1; dir_i[32'h100] = 32'h20;
      dir_k[32'h200] = 2; dir_i[32'h200] = -8;
      step(1, 1, 1, 32'h100, 1, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0);
      chk("t4_jal_npc", if_to_ic_addr, 32'h120);
      step(1, 0, 0, 0, 1, 0, 0);
      chk("t4_jal_dc", {if_to_dc_ready, if_to_dc_PC, if_to_dc_pred_br}, {1'b1, 32'h100, 1'b1});
      step(1, 1, 1, 32'h200, 1, 0, 0);
      step(1, 1, 0, 0, 1, 1, 0);
      chk("t4_br_npc", if_to_ic_addr, 32'h1F8);
      step(1, 0, 0, 0, 1, 0, 0);
      chk("t4_br_dc", {if_to_dc_ready, if_to_dc_PC, if_to_dc_pred_br}, {1'b1, 32'h200, 1'b1});

      // Redirect while waiting on memory: the late response is dropped.
      do_reset();
      mc_lat = 8;
      step(1, 0, 1, 32'h40, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 32'h800, 0, 0, 0);
      chk("t5_req_drop", if_to_mc_ready, 0);
      seen_fill = 0; seen_dc = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         if (if_to_ic_fill_valid) seen_fill = 1;
         if (if_to_dc_ready) seen_dc = 1;
         if (if_to_mc_ready) done = 1;
      end
      chk("t5_new_req", done, 1);
      chk("t5_new_pc", if_to_mc_PC, 32'h800);
      chk("t5_nofill", seen_fill, 0);
      chk("t5_nodc", seen_dc, 0);

      // Redirect in the same cycle as a pop and a hit push.
      do_reset();
      mc_lat = 3;
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 0, 0);
      step(1, 0, 1, 32'h300, 1, 0, 0);
      chk("t6_nodc", if_to_dc_ready, 0);
      chk("t6_pc", if_to_ic_addr, 32'h300);
      step(1, 0, 0, 0, 1, 0, 0);
      chk("t6_empty", if_to_dc_ready, 0);
      step(1, 0, 0, 0, 1, 0, 0);
      chk("t6_dc", {if_to_dc_ready, if_to_dc_PC}, {1'b1, 32'h300});

      // Randomized traffic against the model, with a reset mid-stream.
      do_reset();
      prog_hashed = 1;
      mc_lat_rand = 1;
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset();
         case ($urandom_range(0, 9))
            0:       alt = 32'hFFFFFFC0 + {$urandom_range(0, 15), 2'b00};
            1, 2:    alt = {$urandom(), 2'b00};
            default: alt = {20'h0, $urandom_range(0, 1023), 2'b00};
         endcase
         step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 31) == 0,
              alt, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
